// File: rtl/register_bank_responder.sv
// Register-bank responder: 2^ADDR_WIDTH x DATA_WIDTH registers, one access per chip_enable rising edge.
// Optional REGBANK_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module register_bank_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  chip_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] valueIn,
    output logic [DATA_WIDTH-1:0] valueOut,
    output logic                  ack,
    output logic                  busy,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef REGBANK_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    ce_q;
    logic                    req_edge;
    logic                    capture;
    logic                    req_we_q, req_we_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
    logic [DATA_WIDTH-1:0]   valueOut_q, valueOut_d;
    logic                    ack_q, ack_d;
    logic                    collision_q, collision_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   echo_data;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return ZERO_REG_EN && (addr == '0);
    endfunction

    assign req_edge = chip_enable & ~ce_q;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    capture = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request registers only load when an edge is accepted in IDLE.
    always_comb begin
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        if (capture) begin
            req_we_d   = write_enable;
            req_addr_d = address;
            req_data_d = valueIn;
        end
    end

    always_comb begin
        rd_data     = is_zero_reg(req_addr_q) ? '0 : mem_q[req_addr_q];
        echo_data   = is_zero_reg(req_addr_q) ? '0 : req_data_q;
        mem_we      = (state_q == ACCESS) && req_we_q && !is_zero_reg(req_addr_q);
        valueOut_d  = valueOut_q;
        if (state_q == ACCESS) begin
            valueOut_d = req_we_q ? echo_data : rd_data;
        end
        ack_d       = (state_q == ACCESS);
        collision_d = collision_q | (req_edge & (state_q != IDLE));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ce_q        <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            valueOut_q  <= '0;
            ack_q       <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ce_q        <= chip_enable;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            valueOut_q  <= valueOut_d;
            ack_q       <= ack_d;
            collision_q <= collision_d;
        end
    end

    // Reset clears the whole bank, so an in-flight write never lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[req_addr_q] <= req_data_q;
        end
    end

    assign valueOut  = valueOut_q;
    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);
    assign collision = collision_q;

endmodule

// File: tb/tb_register_bank_responder.sv
// Directed bench for register_bank_responder: timeline model of accepted requests plus literal checks.
module tb_register_bank_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        chip_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  address = '0;
    logic [15:0] valueIn = '0;
    logic [15:0] valueOut;
    logic        ack;
    logic        busy;
    logic        collision;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

`ifdef REGBANK_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    register_bank_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .chip_enable(chip_enable),
        .write_enable(write_enable),
        .address(address),
        .valueIn(valueIn),
        .valueOut(valueOut),
        .ack(ack),
        .busy(busy),
        .collision(collision)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request at edge N is accessed at edge N+1; ack visible
    // after N+1; busy after N and N+1; next edge accepted no earlier than N+3.
    logic [15:0] m_mem [16];
    logic [15:0] m_vout;
    bit          m_col;
    bit          m_prev;
    int          cyc = 0;
    int          last_acc = -100;
    bit          p_we;
    logic [3:0]  p_addr;
    logic [15:0] p_data;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
            m_vout   = 16'h0;
            m_col    = 1'b0;
            m_prev   = 1'b0;
            last_acc = -100;
        end else begin
            if (cyc == last_acc + 1) begin
                if (p_we) begin
                    if (!(ZERO_EN && p_addr == 4'd0)) m_mem[p_addr] = p_data;
                    m_vout = (ZERO_EN && p_addr == 4'd0) ? 16'h0 : p_data;
                end else begin
                    m_vout = (ZERO_EN && p_addr == 4'd0) ? 16'h0 : m_mem[p_addr];
                end
            end
            if (chip_enable && !m_prev) begin
                if (cyc - last_acc >= 3) begin
                    last_acc = cyc;
                    p_we     = write_enable;
                    p_addr   = address;
                    p_data   = valueIn;
                end else begin
                    m_col = 1'b1;
                end
            end
            m_prev = chip_enable;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cmp_valueOut", valueOut, m_vout);
            chk("cmp_ack", {15'h0, ack}, {15'h0, (cyc == last_acc + 1)});
            chk("cmp_busy", {15'h0, busy}, {15'h0, (cyc - last_acc < 2)});
            chk("cmp_collision", {15'h0, collision}, {15'h0, m_col});
        end
    end

    task automatic do_req(input bit we, input logic [3:0] a, input logic [15:0] d,
                          output logic [15:0] vo);
        bit got;
        got          = 1'b0;
        vo           = 'x;
        chip_enable  = 1'b1;
        write_enable = we;
        address      = a;
        valueIn      = d;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clock);
            chip_enable = 1'b0;
            if (ack) begin
                got = 1'b1;
                vo  = valueOut;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_timeout: no ack for addr %0d within 8 cycles", a);
        end
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] v;
        int acks;
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int acks;
        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_valueOut", valueOut, 16'h0000);
        chk("rst_ack", {15'h0, ack}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_collision", {15'h0, collision}, 16'h0);
        reset = 1'b0;
        @(negedge clock);

        // Read of address 5 after reset, cycle by cycle.
        chip_enable = 1'b1; write_enable = 1'b0; address = 4'd5;
        @(negedge clock);
        chip_enable = 1'b0;
        chk("rd5_busy_n", {15'h0, busy}, 16'h1);
        chk("rd5_ack_n", {15'h0, ack}, 16'h0);
        @(negedge clock);
        chk("rd5_busy_n1", {15'h0, busy}, 16'h1);
        chk("rd5_ack_n1", {15'h0, ack}, 16'h1);
        chk("rd5_value", valueOut, 16'h0000);
        @(negedge clock);
        chk("rd5_busy_n2", {15'h0, busy}, 16'h0);
        chk("rd5_ack_n2", {15'h0, ack}, 16'h0);

        do_req(1'b1, 4'd3, 16'hBEEF, v);
        chk("wr3_echo", v, 16'hBEEF);
        do_req(1'b0, 4'd3, 16'h0000, v);
        chk("rd3_value", v, 16'hBEEF);

        // chip_enable held high for 10 cycles: one access only.
        acks = 0;
        chip_enable = 1'b1; write_enable = 1'b1; address = 4'd7; valueIn = 16'h00A7;
        repeat (10) begin
            @(negedge clock);
            if (ack) acks++;
        end
        chip_enable = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (ack) acks++;
        end
        chk("hold_ack_count", acks[15:0], 16'd1);
        do_req(1'b0, 4'd7, 16'h0000, v);
        chk("rd7_value", v, 16'h00A7);

        // Second edge arrives while in DONE: dropped, collision sticks.
        chip_enable = 1'b1; write_enable = 1'b1; address = 4'd2; valueIn = 16'h1111;
        @(negedge clock);
        chip_enable = 1'b0;
        @(negedge clock);
        chip_enable = 1'b1; valueIn = 16'h2222;
        @(negedge clock);
        chip_enable = 1'b0;
        chk("col_set", {15'h0, collision}, 16'h1);
        repeat (2) @(negedge clock);
        do_req(1'b0, 4'd2, 16'h0000, v);
        chk("col_mem_kept", v, 16'h1111);
        chk("col_sticky", {15'h0, collision}, 16'h1);

        // Reset lands on the ACCESS edge of a write to 9.
        chip_enable = 1'b1; write_enable = 1'b1; address = 4'd9; valueIn = 16'h1234;
        @(negedge clock);
        chip_enable = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstw_ack", {15'h0, ack}, 16'h0);
        chk("rstw_busy", {15'h0, busy}, 16'h0);
        chk("rstw_collision", {15'h0, collision}, 16'h0);
        @(negedge clock);
        do_req(1'b0, 4'd9, 16'h0000, v);
        chk("rstw_rd9", v, 16'h0000);
        do_req(1'b0, 4'd3, 16'h0000, v);
        chk("rstw_rd3_cleared", v, 16'h0000);

        // Register 0 behaviour depends on the build option.
        do_req(1'b1, 4'd0, 16'hFFFF, v);
        chk("wr0_echo", v, ZERO_EN ? 16'h0000 : 16'hFFFF);
        do_req(1'b0, 4'd0, 16'h0000, v);
        chk("rd0_value", v, ZERO_EN ? 16'h0000 : 16'hFFFF);

        // Back-to-back write/read on address 15 at minimum spacing.
        do_req(1'b1, 4'd15, 16'h5A5A, v);
        chk("wr15_echo", v, 16'h5A5A);
        do_req(1'b0, 4'd15, 16'h0000, v);
        chk("rd15_value", v, 16'h5A5A);

        repeat (3) @(negedge clock);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
